cv32e40s_obi_master_if: RTL and testbench

Parametrised OBI master adapter sitting between a core-side transaction requester (instruction fetch or LSU) and an external OBI bus. It translates valid/ready transaction requests into OBI A-channel transfers. Address-phase signals stay stable while a request is ungranted. The R channel is passed straight back to the requester. Unlike the fixed instruction-side adapter, it is generic in address/data width and bounds the number of outstanding transactions. It also flags R-channel protocol violations.

---
 rtl/cv32e40s_obi_master_if.sv | 107 ++++++++++
 tb/tb_cv32e40s_obi_master_if.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_obi_master_if.sv
// cv32e40s_obi_master_if: generic OBI master adapter with stable address phase and bounded outstanding count
module cv32e40s_obi_master_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trans_valid_i,
    output logic                    trans_ready_o,
    input  logic [ADDR_WIDTH-1:0]   trans_addr_i,
    input  logic                    trans_we_i,
    input  logic [DATA_WIDTH/8-1:0] trans_be_i,
    input  logic [DATA_WIDTH-1:0]   trans_wdata_i,
    input  logic [2:0]              trans_prot_i,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    obi_req_o,
    output logic                    obi_reqpar_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    output logic [2:0]              obi_prot_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i,
    output logic [CW-1:0]           outstanding_o,
    output logic                    protocol_err_o
);
    typedef enum logic {TRANSPARENT, REGISTERED} state_e;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    state_e                  state_q, state_n;
    logic [CW-1:0]           cnt_q, cnt_n;
    logic                    perr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              prot_q;
    logic                    below_max;
    logic                    capture;
    logic                    inc;
    logic                    dec;
    assign below_max = cnt_q < MAX_CNT;
    always_comb begin
        state_n     = state_q;
        capture     = 1'b0;
        obi_req_o   = 1'b0;
        obi_addr_o  = trans_addr_i;
        obi_we_o    = trans_we_i;
        obi_be_o    = trans_be_i;
        obi_wdata_o = trans_wdata_i;
        obi_prot_o  = trans_prot_i;
        if (state_q == TRANSPARENT) begin
            obi_req_o = trans_valid_i && below_max;
            capture   = obi_req_o && !obi_gnt_i;
            state_n   = capture ? REGISTERED : TRANSPARENT;
        end else begin
            obi_req_o   = 1'b1;
            obi_addr_o  = addr_q;
            obi_we_o    = we_q;
            obi_be_o    = be_q;
            obi_wdata_o = wdata_q;
            obi_prot_o  = prot_q;
            state_n     = obi_gnt_i ? TRANSPARENT : REGISTERED;
        end
    end
    // A response with nothing outstanding is illegal: it is counted as an error, not a decrement
    assign inc   = obi_req_o && obi_gnt_i;
    assign dec   = obi_rvalid_i && (cnt_q != '0);
    assign cnt_n = (inc && !dec) ? cnt_q + 1'b1 :
                   (dec && !inc) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TRANSPARENT;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            prot_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            perr_q  <= perr_q || (obi_rvalid_i && (cnt_q == '0));
            if (capture) begin
                addr_q  <= trans_addr_i;
                we_q    <= trans_we_i;
                be_q    <= trans_be_i;
                wdata_q <= trans_wdata_i;
                prot_q  <= trans_prot_i;
            end
        end
    end
    assign trans_ready_o  = (state_q == TRANSPARENT) && below_max;
    assign obi_reqpar_o   = ~obi_req_o;
    assign resp_valid_o   = obi_rvalid_i;
    assign resp_rdata_o   = obi_rdata_i;
    assign resp_err_o     = obi_err_i;
    assign outstanding_o  = cnt_q;
    assign protocol_err_o = perr_q;
endmodule

// File: tb/tb_cv32e40s_obi_master_if.sv
// tb_cv32e40s_obi_master_if: directed self-checking bench for the OBI master adapter (MAX_OUTSTANDING=2)
module tb_cv32e40s_obi_master_if;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i;
    logic        trans_we_i;
    logic [3:0]  trans_be_i;
    logic [31:0] trans_wdata_i;
    logic [2:0]  trans_prot_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        obi_req_o;
    logic        obi_reqpar_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic [2:0]  obi_prot_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [1:0]  outstanding_o;
    logic        protocol_err_o;
    int n_chk = 0;
    int n_bad = 0;

    cv32e40s_obi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .trans_addr_i(trans_addr_i), .trans_we_i(trans_we_i), .trans_be_i(trans_be_i),
        .trans_wdata_i(trans_wdata_i), .trans_prot_i(trans_prot_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .obi_req_o(obi_req_o), .obi_reqpar_o(obi_reqpar_o), .obi_gnt_i(obi_gnt_i),
        .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_wdata_o(obi_wdata_o), .obi_prot_o(obi_prot_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        trans_valid_i = 1'b0; trans_addr_i = '0; trans_we_i = 1'b0; trans_be_i = 4'hF;
        trans_wdata_i = '0; trans_prot_i = 3'b000; obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        #1;
        check("rst_req", obi_req_o, 0);
        check("rst_reqpar", obi_reqpar_o, 1);
        check("rst_ready", trans_ready_o, 1);
        check("rst_outst", outstanding_o, 0);
        check("rst_perr", protocol_err_o, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        // immediate grant
        trans_valid_i = 1'b1; trans_addr_i = 32'h1000; obi_gnt_i = 1'b1; #1;
        check("imm_req", obi_req_o, 1);
        check("imm_addr", obi_addr_o, 32'h1000);
        check("imm_reqpar", obi_reqpar_o, 0);
        tick;
        trans_valid_i = 1'b0; obi_gnt_i = 1'b0; #1;
        check("imm_outst", outstanding_o, 1);
        check("imm_ready", trans_ready_o, 1);
        // stalled grant: payload must hold while trans_* change
        trans_valid_i = 1'b1; trans_addr_i = 32'h2000; trans_we_i = 1'b1;
        trans_wdata_i = 32'hAAAA5555; trans_prot_i = 3'b101; #1;
        check("stl_req0", obi_req_o, 1);
        check("stl_addr0", obi_addr_o, 32'h2000);
        tick;
        trans_addr_i = 32'h3000; trans_valid_i = 1'b0; trans_we_i = 1'b0;
        trans_wdata_i = 32'h0; trans_prot_i = 3'b000; #1;
        check("stl_req1", obi_req_o, 1);
        check("stl_ready1", trans_ready_o, 0);
        check("stl_addr1", obi_addr_o, 32'h2000);
        check("stl_we1", obi_we_o, 1);
        check("stl_wdata1", obi_wdata_o, 32'hAAAA5555);
        check("stl_prot1", obi_prot_o, 3'b101);
        tick;
        obi_gnt_i = 1'b1; #1;
        check("stl_req2", obi_req_o, 1);
        check("stl_ready2", trans_ready_o, 0);
        check("stl_addr2", obi_addr_o, 32'h2000);
        tick;
        // now at the limit: cnt == 2
        obi_gnt_i = 1'b0; trans_valid_i = 1'b1; trans_addr_i = 32'h4000; #1;
        check("lim_outst", outstanding_o, 2);
        check("lim_req", obi_req_o, 0);
        check("lim_ready", trans_ready_o, 0);
        check("lim_addr_transparent", obi_addr_o, 32'h4000);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h12345678; #1;
        check("lim_req_rvalid", obi_req_o, 0);
        check("lim_resp_valid", resp_valid_o, 1);
        check("lim_resp_rdata", resp_rdata_o, 32'h12345678);
        tick;
        obi_rvalid_i = 1'b0; #1;
        check("lim_outst_dec", outstanding_o, 1);
        check("lim_req_back", obi_req_o, 1);
        check("lim_ready_back", trans_ready_o, 1);
        // simultaneous inc and dec at cnt == 1
        obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEADBEEF; obi_err_i = 1'b1; #1;
        check("sim_resp_valid", resp_valid_o, 1);
        check("sim_resp_rdata", resp_rdata_o, 32'hDEADBEEF);
        check("sim_resp_err", resp_err_o, 1);
        tick;
        trans_valid_i = 1'b0; obi_gnt_i = 1'b0; obi_err_i = 1'b0; #1;
        check("sim_outst", outstanding_o, 1);
        tick;
        obi_rvalid_i = 1'b0; #1;
        check("drain_outst", outstanding_o, 0);
        check("drain_perr", protocol_err_o, 0);
        // protocol error: rvalid with nothing outstanding
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hCAFEF00D; #1;
        check("perr_resp_valid", resp_valid_o, 1);
        check("perr_resp_rdata", resp_rdata_o, 32'hCAFEF00D);
        check("perr_not_yet", protocol_err_o, 0);
        tick;
        obi_rvalid_i = 1'b0; #1;
        check("perr_outst", outstanding_o, 0);
        check("perr_set", protocol_err_o, 1);
        tick; tick;
        check("perr_sticky", protocol_err_o, 1);
        check("perr_outst_hold", outstanding_o, 0);
        // reset while in REGISTERED
        trans_valid_i = 1'b1; trans_addr_i = 32'h5000; #1;
        tick;
        trans_valid_i = 1'b0; #1;
        check("rr_ready_stalled", trans_ready_o, 0);
        check("rr_req_stalled", obi_req_o, 1);
        check("rr_outst_pre", outstanding_o, 0);
        rst_n = 1'b0; #1;
        check("rr_req", obi_req_o, 0);
        check("rr_reqpar", obi_reqpar_o, 1);
        check("rr_ready", trans_ready_o, 1);
        check("rr_outst", outstanding_o, 0);
        check("rr_perr", protocol_err_o, 0);
        tick;
        rst_n = 1'b1;
        trans_valid_i = 1'b1; trans_addr_i = 32'h6000; #1;
        check("post_req", obi_req_o, 1);
        check("post_addr", obi_addr_o, 32'h6000);
        tick;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
